// File: rtl/seq_pkg.sv
// Shared encodings for the event sequencer and the sleep/wake FSM it drives.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StCheck,
    StGap,
    StFinish,
    StErr
  } seq_state_e;

  // FSM event codes (3-bit) presented on fsm_input
  localparam logic [2:0] EvNone  = 3'b000;
  localparam logic [2:0] EvWake  = 3'b001;
  localparam logic [2:0] EvSleep = 3'b010;
  localparam logic [2:0] EvTick  = 3'b100;

  // FSM Moore output codes (6-bit) observed on fsm_output
  localparam logic [5:0] OutSleep  = 6'b000000;
  localparam logic [5:0] OutAwake0 = 6'b100001;
  localparam logic [5:0] OutAwake1 = 6'b100010;
  localparam logic [5:0] OutAwake2 = 6'b100011;

  typedef struct packed {
    logic [2:0] event_code;
    logic [5:0] expect_code;
  } script_entry_t;

  function automatic logic [3:0] clamp_steps(input logic [3:0] n, input logic [3:0] limit);
    return (n > limit) ? limit : n;
  endfunction

endpackage

// File: rtl/event_script_mem.sv
// Script storage: DEPTH entries of {event, expected response}, one write and one
// asynchronous read port. Not reset, so scripts survive a sequencer reset.
module event_script_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  script_entry_t wr_data,
  input  logic [2:0]    rd_addr,
  output script_entry_t rd_data
);

  script_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/event_sequencer.sv
// Scripted stimulus sequencer: drives one event per step into an FSM, checks its
// Moore response one cycle later, and reports pass (done) or the first mismatch.
module event_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter logic [2:0]  IDLE_EVENT = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_event,
  input  logic [5:0] wr_expect,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] num_steps,
  input  logic [3:0] gap,
  input  logic [5:0] fsm_output,
  output logic [2:0] fsm_input,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] fail_step,
  output logic [5:0] fail_value
);

  localparam logic [3:0] DepthSteps = 4'(DEPTH);

  seq_state_e    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [3:0]    nsteps_q, nsteps_d;
  logic [3:0]    gap_q, gap_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [5:0]    exp_q;
  logic [3:0]    start_steps;
  logic          last_step;
  logic          match;
  script_entry_t wr_data;
  script_entry_t rd_data;

  assign wr_data = '{event_code: wr_event, expect_code: wr_expect};

  // Read address follows the next step so the entry is ready as DRIVE is entered.
  event_script_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (step_d),
    .rd_data (rd_data)
  );

  assign start_steps = clamp_steps(num_steps, DepthSteps);
  assign last_step   = ({1'b0, step_q} == (nsteps_q - 4'd1));
  assign match       = (fsm_output == exp_q);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    nsteps_d  = nsteps_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle, StFinish, StErr: begin
        if (start && !abort) begin
          nsteps_d = start_steps;
          gap_d    = gap;
          step_d   = 3'd0;
          state_d  = (start_steps == 4'd0) ? StFinish : StDrive;
        end else if (state_q == StFinish) begin
          state_d = StIdle;
        end
      end
      StDrive: state_d = abort ? StIdle : StCheck;
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!match) begin
          state_d = StErr;
        end else if (last_step) begin
          state_d = StFinish;
        end else begin
          step_d = step_q + 3'd1;
          if (gap_q != 4'd0) begin
            gap_cnt_d = gap_q - 4'd1;
            state_d   = StGap;
          end else begin
            state_d = StDrive;
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else if (gap_cnt_q == 4'd0) begin
          state_d = StDrive;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= 3'd0;
      nsteps_q   <= 4'd0;
      gap_q      <= 4'd0;
      gap_cnt_q  <= 4'd0;
      exp_q      <= 6'd0;
      fsm_input  <= IDLE_EVENT;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      fail_step  <= 3'd0;
      fail_value <= 6'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      nsteps_q  <= nsteps_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      fsm_input <= (state_d == StDrive) ? rd_data.event_code : IDLE_EVENT;
      if (state_d == StDrive) begin
        exp_q <= rd_data.expect_code;
      end
      busy  <= (state_d == StDrive) || (state_d == StCheck) || (state_d == StGap);
      done  <= (state_d == StFinish);
      error <= (state_d == StErr);
      if ((state_q == StCheck) && (state_d == StErr)) begin
        fail_step  <= step_q;
        fail_value <= fsm_output;
      end
    end
  end

endmodule

// File: tb/tb_event_sequencer.sv
// Scoreboard bench for event_sequencer driving a behavioural sleep/wake FSM.
module tb_event_sequencer
  import seq_pkg::*;
;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [2:0] wr_event = 3'd0;
  logic [5:0] wr_expect = 6'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] num_steps = 4'd0;
  logic [3:0] gap = 4'd0;
  logic [5:0] fsm_output;
  logic [2:0] fsm_input;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] fail_step;
  logic [5:0] fail_value;
  logic       fsm_rst = 1'b1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] fin;
    logic       busy;
    logic       done;
    logic       err;
    bit         chk_fail;
    logic [2:0] fstep;
    logic [5:0] fval;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  event_sequencer #(
    .DEPTH      (8),
    .IDLE_EVENT (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_event   (wr_event),
    .wr_expect  (wr_expect),
    .start      (start),
    .abort      (abort),
    .num_steps  (num_steps),
    .gap        (gap),
    .fsm_output (fsm_output),
    .fsm_input  (fsm_input),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .fail_step  (fail_step),
    .fail_value (fail_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sleep/wake FSM standing in for the device under drive.
  always @(posedge clk) begin
    if (fsm_rst) begin
      fsm_output <= OutSleep;
    end else begin
      case (fsm_input)
        EvWake:  if (fsm_output == OutSleep) fsm_output <= OutAwake0;
        EvTick: begin
          if (fsm_output == OutAwake0) fsm_output <= OutAwake1;
          else if (fsm_output == OutAwake1) fsm_output <= OutAwake2;
        end
        EvSleep: fsm_output <= OutSleep;
        default: ;
      endcase
    end
  end

  // Monitor: pop the entry scheduled for this cycle and compare.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: entry for cycle %0d never compared (now %0d)", sb[0].tag, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if ({fsm_input, busy, done, error} !== {mon_e.fin, mon_e.busy, mon_e.done, mon_e.err}) begin
        errors++;
        $display("FAIL %s cyc %0d: fsm_input/busy/done/error got %b/%b/%b/%b want %b/%b/%b/%b",
                 mon_e.tag, cyc, fsm_input, busy, done, error,
                 mon_e.fin, mon_e.busy, mon_e.done, mon_e.err);
      end
      if (mon_e.chk_fail) begin
        checks++;
        if ({fail_step, fail_value} !== {mon_e.fstep, mon_e.fval}) begin
          errors++;
          $display("FAIL %s cyc %0d: fail_step/fail_value got %0d/%b want %0d/%b",
                   mon_e.tag, cyc, fail_step, fail_value, mon_e.fstep, mon_e.fval);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // off = 1 is the cycle right after the next clock edge.
  task automatic push(input int off, input string tag, input logic [2:0] fin, input logic b,
                      input logic d, input logic e, input bit cf = 1'b0,
                      input logic [2:0] fs = 3'd0, input logic [5:0] fv = 6'd0);
    exp_t x;
    x.cyc = cyc + off;
    x.tag = tag;
    x.fin = fin;
    x.busy = b;
    x.done = d;
    x.err = e;
    x.chk_fail = cf;
    x.fstep = fs;
    x.fval = fv;
    sb.push_back(x);
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [2:0] ev, input logic [5:0] ex);
    wr_en = 1'b1;
    wr_addr = a;
    wr_event = ev;
    wr_expect = ex;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fsm_reset();
    fsm_rst = 1'b1;
    tick();
    fsm_rst = 1'b0;
  endtask

  task automatic run(input logic [3:0] n, input logic [3:0] g);
    num_steps = n;
    gap = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Expected trace of the three-step passing script with gap=0.
  task automatic push_pass3(input string tag);
    push(1, tag, EvWake, 1, 0, 0);
    push(2, tag, EvNone, 1, 0, 0);
    push(3, tag, EvTick, 1, 0, 0);
    push(4, tag, EvNone, 1, 0, 0);
    push(5, tag, EvTick, 1, 0, 0);
    push(6, tag, EvNone, 1, 0, 0);
    push(7, tag, EvNone, 0, 1, 0);
    push(8, tag, EvNone, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] evs [8];
    evs = '{EvWake, EvTick, EvTick, EvNone, EvNone, EvNone, EvNone, EvNone};

    tick();
    push(1, "reset", EvNone, 0, 0, 0, 1'b1, 3'd0, 6'd0);
    tick();
    reset = 1'b0;
    fsm_rst = 1'b0;
    drain();

    write_entry(3'd0, EvWake, OutAwake0);
    write_entry(3'd1, EvTick, OutAwake1);
    write_entry(3'd2, EvTick, OutAwake2);
    for (int i = 3; i < 8; i++) write_entry(3'(i), EvNone, OutAwake2);

    fsm_reset();
    push_pass3("pass");
    run(4'd3, 4'd0);
    drain();

    write_entry(3'd1, EvTick, OutAwake2);
    fsm_reset();
    push(1, "mismatch", EvWake, 1, 0, 0);
    push(2, "mismatch", EvNone, 1, 0, 0);
    push(3, "mismatch", EvTick, 1, 0, 0);
    push(4, "mismatch", EvNone, 1, 0, 0);
    push(5, "mismatch", EvNone, 0, 0, 1, 1'b1, 3'd1, OutAwake1);
    push(6, "mismatch", EvNone, 0, 0, 1, 1'b1, 3'd1, OutAwake1);
    run(4'd3, 4'd0);
    drain();
    write_entry(3'd1, EvTick, OutAwake1);

    fsm_reset();
    push(1, "gap3", EvWake, 1, 0, 0);
    push(2, "gap3", EvNone, 1, 0, 0);
    for (int i = 3; i <= 5; i++) push(i, "gap3", EvNone, 1, 0, 0);
    push(6, "gap3", EvTick, 1, 0, 0);
    push(7, "gap3", EvNone, 1, 0, 0);
    for (int i = 8; i <= 10; i++) push(i, "gap3", EvNone, 1, 0, 0);
    push(11, "gap3", EvTick, 1, 0, 0);
    push(12, "gap3", EvNone, 1, 0, 0);
    push(13, "gap3", EvNone, 0, 1, 0);
    push(14, "gap3", EvNone, 0, 0, 0);
    run(4'd3, 4'd3);
    drain();

    push(1, "zero_steps", EvNone, 0, 1, 0);
    push(2, "zero_steps", EvNone, 0, 0, 0);
    run(4'd0, 4'd0);
    drain();

    fsm_reset();
    for (int k = 0; k < 8; k++) begin
      push(2 * k + 1, "clamp", evs[k], 1, 0, 0);
      push(2 * k + 2, "clamp", EvNone, 1, 0, 0);
    end
    push(17, "clamp", EvNone, 0, 1, 0);
    push(18, "clamp", EvNone, 0, 0, 0);
    run(4'd15, 4'd0);
    drain();

    fsm_reset();
    push(1, "abort", EvWake, 1, 0, 0);
    push(2, "abort", EvNone, 1, 0, 0);
    push(3, "abort", EvNone, 1, 0, 0);
    for (int i = 4; i <= 6; i++) push(i, "abort", EvNone, 0, 0, 0);
    run(4'd3, 4'd3);
    tick();
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    drain();

    fsm_reset();
    push_pass3("busy_wr");
    num_steps = 4'd3;
    gap = 4'd0;
    start = 1'b1;
    tick();
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_event = EvSleep;
    wr_expect = OutSleep;
    num_steps = 4'd0;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    drain();
    fsm_reset();
    push_pass3("after_busy_wr");
    run(4'd3, 4'd0);
    drain();

    fsm_reset();
    push(1, "mid_reset", EvWake, 1, 0, 0);
    push(2, "mid_reset", EvNone, 1, 0, 0);
    push(3, "mid_reset", EvNone, 0, 0, 0, 1'b1, 3'd0, 6'd0);
    push(4, "mid_reset", EvNone, 0, 0, 0);
    run(4'd3, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drain();
    fsm_reset();
    push_pass3("after_reset");
    run(4'd3, 4'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/event_sequencer.md
EVENT_SEQUENCER -- requirements
Module: event_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, sets the number of script entries.
REQ-002 Parameter IDLE_EVENT, default 3'b000, sets the event code driven when no step is active.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  script write strobe.
REQ-006 wr_addr  input  3  script entry index.
REQ-007 wr_event  input  3  event code to store.
REQ-008 wr_expect  input  6  expected FSM response to store.
REQ-009 start  input  1  run-request pulse.
REQ-010 abort  input  1  stop the current run.
REQ-011 num_steps  input  4  number of steps to run; sampled on start.
REQ-012 gap  input  4  idle cycles between steps; sampled on start.
REQ-013 fsm_output  input  6  Moore response from the sleep/wake FSM under drive.
REQ-014 fsm_input  output  3  event code presented to the FSM.
REQ-015 busy  output  1  high while in DRIVE, CHECK or GAP.
REQ-016 done  output  1  one-cycle pulse when a run passes.
REQ-017 error  output  1  level, set on a response mismatch.
REQ-018 fail_step  output  3  index of the step that mismatched.
REQ-019 fail_value  output  6  fsm_output value captured at the mismatch.

Function
REQ-020 States SHALL be IDLE, DRIVE, CHECK, GAP, FINISH, ERR.
REQ-021 wr_en SHALL write entry wr_addr only when busy=0; writes with busy=1 SHALL be ignored.
REQ-022 start in IDLE, FINISH or ERR SHALL do the following at that edge:
  - latch num_steps, clamped to DEPTH;
  - latch gap;
  - set step index to 0;
  - clear error;
  - go to DRIVE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 If the latched num_steps is 0, start SHALL go directly to FINISH without driving any event.
REQ-025 DRIVE SHALL last exactly 1 cycle, with fsm_input = script event[step]; the next state SHALL be CHECK.
REQ-026 In CHECK, fsm_input SHALL be IDLE_EVENT, and the block SHALL compare fsm_output against expect[step]. The response latency is fixed at 1 cycle after DRIVE.
REQ-027 On a CHECK match when the step is not the last:
  - increment step;
  - go to GAP if gap>0, otherwise go to DRIVE.
REQ-028 On a CHECK match on the last step, the block SHALL go to FINISH.
REQ-029 On a CHECK mismatch, the block SHALL:
  - capture fail_step = step and fail_value = fsm_output;
  - go to ERR.
REQ-030 GAP SHALL hold fsm_input = IDLE_EVENT for exactly gap cycles, then go to DRIVE.
REQ-031 FINISH SHALL assert done for 1 cycle, then go to IDLE unless start is high.
REQ-032 ERR SHALL hold error=1 until start or reset.
REQ-033 abort in DRIVE, CHECK or GAP SHALL go to IDLE at the next edge, with fsm_input = IDLE_EVENT and no done pulse.
REQ-034 abort and start asserted together SHALL resolve as abort.
REQ-035 The step index SHALL never exceed DEPTH-1 and SHALL not wrap.
REQ-036 fsm_input SHALL be registered, and equal IDLE_EVENT in every state except DRIVE.

Reset
REQ-037 reset SHALL override all other inputs and set the following at the next edge:
  - state = IDLE;
  - fsm_input = IDLE_EVENT;
  - busy = 0, done = 0, error = 0;
  - fail_step = 0, fail_value = 0.
REQ-038 Reset SHALL take effect even in the middle of a run.
REQ-039 Script contents SHALL be unaffected by reset.

Structure
REQ-040 A shared package seq_pkg SHALL hold the sequencer state encodings plus the FSM event codes (3-bit) and output codes (6-bit), so that the FSM and the sequencer use common values.
REQ-041 The script storage SHALL be one sub-module, event_script_mem, with 1 write port and 1 read port, DEPTH x 9 bits.

Verification
REQ-042 Pass run:
  - script {001/100001, 100/100010, 100/100011}, num_steps=3, gap=0, FSM in reset-idle;
  - required: fsm_input shows 001,000,100,000,100,000;
  - required: done pulses once; error=0.
REQ-043 Mismatch: same script with expect[1]=100011 -> error=1, fail_step=1, fail_value=100010, no done pulse.
REQ-044 Gap and zero steps:
  - gap=3 -> exactly 3 cycles of 000 between each CHECK and the following DRIVE;
  - num_steps=0 -> done pulses 1 cycle after start, and fsm_input never leaves 000.
REQ-045 Abort during GAP of step 1 -> busy=0 at the next cycle, no done pulse, error=0.
REQ-046 Writes and start while busy:
  - wr_en during a run -> script entry unchanged after the run;
  - start while busy -> ignored.
REQ-047 reset asserted during CHECK -> all outputs at reset values the next cycle; a later run without rewriting the script passes.
